// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display converter.
// Imported by the converter top and its digit-adjust helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    localparam int ACC_DIG = 10;
    localparam int NITER   = 32;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Purely combinational; one instance per accumulator digit.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_display.sv
// Self-triggering sequential binary-to-BCD converter feeding the hex drivers.
// Reconverts whenever the CPU output word differs from the last accepted one.
module bin2bcd_display
    import bin2bcd_pkg::*;
#(
    parameter int W    = 32,
    parameter int NDIG = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      bin_in,
    output logic [4*NDIG-1:0] bcd_out,
    output logic              ovf,
    output logic              busy
);

    localparam int ACCW = 4 * ACC_DIG;
    localparam logic [4:0] LAST_CNT = 5'(NITER - 1);

    b2b_state_t        state_q;
    logic [W-1:0]      last_bin_q;
    logic [W-1:0]      sh_q;
    logic [W-1:0]      sh_d;
    logic [ACCW-1:0]   acc_q;
    logic [ACCW-1:0]   acc_adj;
    logic [ACCW-1:0]   acc_d;
    logic [4:0]        cnt_q;
    logic [4*NDIG-1:0] bcd_q;
    logic              ovf_q;

    for (genvar g = 0; g < ACC_DIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (acc_q[4*g +: 4]),
            .d_o (acc_adj[4*g +: 4])
        );
    end

    // One double-dabble step: adjust all digits, then shift {acc, sh} left.
    assign acc_d = {acc_adj[ACCW-2:0], sh_q[W-1]};
    assign sh_d  = {sh_q[W-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_bin_q <= '0;
            sh_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bin_in != last_bin_q) begin
                        sh_q       <= bin_in;
                        last_bin_q <= bin_in;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= acc_q[4*NDIG-1:0];
                    ovf_q   <= |acc_q[ACCW-1:4*NDIG];
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bin2bcd_display.sv
// Directed and randomized checks of bin2bcd_display against a decimal model.
module tb_bin2bcd_display;

    logic        clk;
    logic        rst_n;
    logic [31:0] bin_in;
    logic [31:0] bcd_out;
    logic        ovf;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    bin2bcd_display #(.W(32), .NDIG(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bin_in  (bin_in),
        .bcd_out (bcd_out),
        .ovf     (ovf),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] v);
        @(negedge clk);
        bin_in = v;
    endtask

    // Decimal model: low eight decimal digits, flag for values above 10^8-1.
    function automatic logic [31:0] ref_bcd(input logic [31:0] v);
        longint unsigned x;
        logic [31:0] r;
        x = longint'(v) % 64'd100000000;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] v);
        return v > 32'd99999999;
    endfunction

    // Apply a value, then wait (bounded) for busy to drop; returns edge count.
    task automatic run_conv(input logic [31:0] v, output int edges);
        drive(v);
        tick();
        edges = 1;
        while (busy === 1'b1 && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    task automatic conv_chk(input string tag, input logic [31:0] v);
        int e;
        run_conv(v, e);
        chk({tag, " edges"}, 40'(e), 40'd34);
        chk({tag, " bcd"}, 40'(bcd_out), 40'(ref_bcd(v)));
        chk({tag, " ovf"}, 40'(ovf), 40'(ref_ovf(v)));
    endtask

    initial begin
        int          seen_busy;
        int          bad;
        int          n;
        logic [31:0] prev;
        logic [31:0] last;
        logic [31:0] v;
        int          e;

        rst_n  = 1'b0;
        bin_in = 32'd0;
        repeat (3) tick();
        chk("rst bcd", 40'(bcd_out), 40'h0);
        chk("rst ovf", 40'(ovf), 40'h0);
        chk("rst busy", 40'(busy), 40'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_busy = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy !== 1'b0 || bcd_out !== 32'h0) seen_busy++;
        end
        chk("idle no conv", 40'(seen_busy), 40'd0);

        // Exact edge timing of a single conversion.
        drive(32'd12345);
        tick();
        chk("basic busy rise", 40'(busy), 40'h1);
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (bcd_out !== 32'h0 || busy !== 1'b1) bad++;
        end
        chk("basic stable", 40'(bad), 40'd0);
        tick();
        chk("basic bcd k+33", 40'(bcd_out), 40'h00012345);
        chk("basic ovf", 40'(ovf), 40'h0);
        tick();
        chk("basic busy fall", 40'(busy), 40'h0);

        conv_chk("max8", 32'd99999999);
        chk("max8 lit", 40'(bcd_out), 40'h99999999);
        conv_chk("1e8", 32'd100000000);
        chk("1e8 ovf lit", 40'(ovf), 40'h1);
        conv_chk("allones", 32'hFFFFFFFF);
        chk("allones lit", 40'(bcd_out), 40'h94967295);

        // Change mid-conversion: first result kept, then reconverted.
        prev = bcd_out;
        drive(32'd42);
        tick();
        bad = 0;
        for (int i = 1; i <= 33; i++) begin
            if (i == 11) begin
                @(negedge clk);
                bin_in = 32'd7;
            end
            tick();
            if (i < 33 && bcd_out !== prev) bad++;
        end
        chk("mid first", 40'(bcd_out), 40'h00000042);
        tick();
        chk("mid restart busy", 40'(busy), 40'h1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
            if (bcd_out !== 32'h42 && bcd_out !== 32'h7) bad++;
        end
        chk("mid final", 40'(bcd_out), 40'h00000007);
        chk("mid no partial", 40'(bad), 40'd0);

        // Reset in the middle of a conversion.
        drive(32'h3039);
        tick();
        repeat (14) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid bcd", 40'(bcd_out), 40'h0);
        chk("rstmid ovf", 40'(ovf), 40'h0);
        chk("rstmid busy", 40'(busy), 40'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bcd_out !== 32'h00012345 && n < 100) begin
            tick();
            n++;
        end
        chk("rstmid edges", 40'(n), 40'd34);
        chk("rstmid bcd", 40'(bcd_out), 40'h00012345);
        tick();

        // Randomized values against the decimal model.
        last = 32'h3039;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            v = $urandom;
            if (v == last) v = v ^ 32'h1;
            run_conv(v, e);
            last = v;
            n_assert++;
            assert (e == 34 && bcd_out === ref_bcd(v) && ovf === ref_ovf(v))
            else begin
                n_fail++;
                $error("FAIL rand v=%h: observed bcd %h ovf %b edges %0d expected bcd %h ovf %b edges 34",
                       v, bcd_out, ovf, e, ref_bcd(v), ref_ovf(v));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
